// File: rtl/mem_port_arb_pkg.sv
// Shared types for the RAM data-port arbiter.
// The optional round-robin mode is enabled with MEM_PORT_ARB_RR_EN.
package mem_port_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        READ   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_port_arb_pick.sv
// Combinational winner selection between CPU and host.
// MEM_PORT_ARB_RR_EN selects round-robin; otherwise the host has fixed priority.
module mem_port_arb_pick
    import mem_port_arb_pkg::*;
(
    input  logic cpu_elig,
    input  logic host_elig,
    input  logic last_owner,
    output logic winner
);

`ifdef MEM_PORT_ARB_RR_EN
    always_comb begin
        winner = OWN_CPU;
        if (cpu_elig && host_elig) begin
            winner = (last_owner == OWN_HOST) ? OWN_CPU : OWN_HOST;
        end else if (host_elig) begin
            winner = OWN_HOST;
        end
    end
`else
    always_comb begin
        winner = OWN_CPU;
        if (host_elig) begin
            winner = OWN_HOST;
        end else if (!cpu_elig) begin
            // Nobody eligible: the result is ignored, so any value will do.
            winner = last_owner;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialising arbiter for the shared RAM data port (CPU datapath vs host front-end).
// Round-robin arbitration is enabled by defining MEM_PORT_ARB_RR_EN.
module mem_port_arbiter
    import mem_port_arb_pkg::*;
#(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          nrst,

    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic          cpu_gnt_o,
    output logic          cpu_rvalid_o,
    output logic [DW-1:0] cpu_rdata_o,

    input  logic          host_req_i,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [DW-1:0] host_wdata_i,
    output logic          host_gnt_o,
    output logic          host_rvalid_o,
    output logic [DW-1:0] host_rdata_o,

    input  logic          host_lock_i,

    output logic          ram_we_o,
    output logic          ram_re_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_wdata_o,
    input  logic [DW-1:0] ram_rdata_i,

    output logic          cpu_stall_o,
    output logic          busy_o
);

    // Handshake: a requester holds req (with we/addr/wdata) until it sees a
    // one-cycle gnt, which marks the cycle its access is driven to the RAM.
    // Read data follows two cycles after gnt as a one-cycle rvalid pulse;
    // req still high when the FSM is back in IDLE starts a new transaction.

    arb_state_t    state;
    arb_state_t    next_state;
    arb_owner_t    own_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] host_rdata_q;
    logic          cpu_rvalid_q;
    logic          host_rvalid_q;

    logic cpu_elig;
    logic host_elig;
    logic any_elig;
    logic winner;
    logic last_owner;
    logic start;

    assign cpu_elig  = cpu_req_i & ~host_lock_i;
    assign host_elig = host_req_i;
    assign any_elig  = cpu_elig | host_elig;
    assign start     = (state == IDLE) && any_elig;

    mem_port_arb_pick u_pick (
        .cpu_elig   (cpu_elig),
        .host_elig  (host_elig),
        .last_owner (last_owner),
        .winner     (winner)
    );

`ifdef MEM_PORT_ARB_RR_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            last_owner <= OWN_CPU;
        end else if (start) begin
            last_owner <= winner;
        end
    end
`else
    assign last_owner = OWN_CPU;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        ram_we_o    = 1'b0;
        ram_re_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        cpu_gnt_o   = 1'b0;
        host_gnt_o  = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_elig) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                ram_we_o    = we_q;
                ram_re_o    = ~we_q;
                ram_addr_o  = addr_q;
                ram_wdata_o = wdata_q;
                cpu_gnt_o   = (own_q == OWN_CPU);
                host_gnt_o  = (own_q == OWN_HOST);
                next_state  = we_q ? IDLE : READ;
            end
            READ: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            own_q   <= OWN_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (start) begin
            own_q <= arb_owner_t'(winner);
            if (winner == OWN_HOST) begin
                we_q    <= host_we_i;
                addr_q  <= host_addr_i;
                wdata_q <= host_wdata_i;
            end else begin
                we_q    <= cpu_we_i;
                addr_q  <= cpu_addr_i;
                wdata_q <= cpu_wdata_i;
            end
        end
    end

    // RAM data is valid during READ; capture it so rvalid and data line up next cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cpu_rdata_q   <= '0;
            host_rdata_q  <= '0;
            cpu_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
        end else begin
            cpu_rvalid_q  <= (state == READ) && (own_q == OWN_CPU);
            host_rvalid_q <= (state == READ) && (own_q == OWN_HOST);
            if (state == READ) begin
                if (own_q == OWN_CPU) begin
                    cpu_rdata_q <= ram_rdata_i;
                end else begin
                    host_rdata_q <= ram_rdata_i;
                end
            end
        end
    end

    assign cpu_rvalid_o  = cpu_rvalid_q;
    assign host_rvalid_o = host_rvalid_q;
    assign cpu_rdata_o   = cpu_rdata_q;
    assign host_rdata_o  = host_rdata_q;
    assign cpu_stall_o   = cpu_req_i & ~cpu_gnt_o;
    assign busy_o        = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants/read returns are queued
// with their cycle numbers and checked by an independent monitor.
module tb_mem_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int GW = 32 + 1 + 1 + AW + DW;
    localparam int RW = 32 + 1 + DW;

    logic          clk = 1'b0;
    logic          nrst;
    logic          cpu_req_i, cpu_we_i;
    logic [AW-1:0] cpu_addr_i;
    logic [DW-1:0] cpu_wdata_i;
    logic          cpu_gnt_o, cpu_rvalid_o;
    logic [DW-1:0] cpu_rdata_o;
    logic          host_req_i, host_we_i;
    logic [AW-1:0] host_addr_i;
    logic [DW-1:0] host_wdata_i;
    logic          host_gnt_o, host_rvalid_o;
    logic [DW-1:0] host_rdata_o;
    logic          host_lock_i;
    logic          ram_we_o, ram_re_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_wdata_o;
    logic [DW-1:0] ram_rdata_i = '0;
    logic          cpu_stall_o, busy_o;

    logic [GW-1:0] gnt_q[$];
    logic [RW-1:0] rd_q[$];
    int            rv_cyc_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .cpu_req_i     (cpu_req_i),
        .cpu_we_i      (cpu_we_i),
        .cpu_addr_i    (cpu_addr_i),
        .cpu_wdata_i   (cpu_wdata_i),
        .cpu_gnt_o     (cpu_gnt_o),
        .cpu_rvalid_o  (cpu_rvalid_o),
        .cpu_rdata_o   (cpu_rdata_o),
        .host_req_i    (host_req_i),
        .host_we_i     (host_we_i),
        .host_addr_i   (host_addr_i),
        .host_wdata_i  (host_wdata_i),
        .host_gnt_o    (host_gnt_o),
        .host_rvalid_o (host_rvalid_o),
        .host_rdata_o  (host_rdata_o),
        .host_lock_i   (host_lock_i),
        .ram_we_o      (ram_we_o),
        .ram_re_o      (ram_re_o),
        .ram_addr_o    (ram_addr_o),
        .ram_wdata_o   (ram_wdata_o),
        .ram_rdata_i   (ram_rdata_i),
        .cpu_stall_o   (cpu_stall_o),
        .busy_o        (busy_o)
    );

    // ---------------- clock / reset / RAM model ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        case (a)
            12'h001: return 32'h1111_1111;
            12'h002: return 32'h2222_2222;
            12'h020: return 32'h0000_0007;
            default: return {20'h0, a};
        endcase
    endfunction

    always @(posedge clk) begin
        if (ram_re_o) ram_rdata_i <= ram_word(ram_addr_o);
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [GW-1:0] ge;
        logic [RW-1:0] re;
        if (cpu_gnt_o || host_gnt_o) begin
            check("gnt_exclusive", {cpu_gnt_o, host_gnt_o}, cpu_gnt_o ? 2'b10 : 2'b01);
            check("strobe_exclusive", ram_we_o & ram_re_o, 0);
            if (gnt_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_gnt actual cyc=%0d host=%0b required none", cyc, host_gnt_o);
            end else begin
                ge = gnt_q.pop_front();
                check("gnt", {32'(cyc), host_gnt_o, ram_we_o, ram_addr_o, ram_wdata_o}, ge);
            end
        end else begin
            check("idle_ram_outputs", {ram_we_o, ram_re_o, ram_addr_o, ram_wdata_o}, 0);
        end
        if (cpu_rvalid_o) begin
            rv_cyc_q.push_back(cyc);
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cpu_rvalid actual cyc=%0d required none", cyc);
            end else begin
                re = rd_q.pop_front();
                check("cpu_rvalid", {32'(cyc), 1'b0, cpu_rdata_o}, re);
            end
        end
        if (host_rvalid_o) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_host_rvalid actual cyc=%0d required none", cyc);
            end else begin
                re = rd_q.pop_front();
                check("host_rvalid", {32'(cyc), 1'b1, host_rdata_o}, re);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_wdata_i = '0;
        host_req_i = 0; host_we_i = 0; host_addr_i = '0; host_wdata_i = '0;
        host_lock_i = 0;
    endtask

    function automatic logic [GW-1:0] g_ent(input int c, input logic host, input logic we,
                                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {32'(c), host, we, a, d};
    endfunction

    function automatic logic [RW-1:0] r_ent(input int c, input logic host, input logic [DW-1:0] d);
        return {32'(c), host, d};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int  c;
        bit  found;
        nrst = 0;
        clear_inputs();
        cpu_req_i = 1;
        #2;
        check("rst_busy", busy_o, 0);
        check("rst_gnts", {cpu_gnt_o, host_gnt_o}, 0);
        check("rst_rvalids", {cpu_rvalid_o, host_rvalid_o}, 0);
        check("rst_rdata", {cpu_rdata_o, host_rdata_o}, 0);
        check("rst_ram", {ram_we_o, ram_re_o, ram_addr_o, ram_wdata_o}, 0);
        check("rst_stall_follows_req1", cpu_stall_o, 1);
        cpu_req_i = 0;
        #1;
        check("rst_stall_follows_req0", cpu_stall_o, 0);
        tick(); tick();
        nrst = 1;
        tick();

        // CPU write
        c = cyc;
        cpu_req_i = 1; cpu_we_i = 1; cpu_addr_i = 12'h010; cpu_wdata_i = 32'hDEAD_BEEF;
        gnt_q.push_back(g_ent(c + 1, 1'b0, 1'b1, 12'h010, 32'hDEAD_BEEF));
        tick();
        cpu_req_i = 0;
        sample(); check("wr_busy_c1", busy_o, 1);
        tick();
        sample(); check("wr_busy_c2", busy_o, 0);

        // host read
        tick();
        c = cyc;
        host_req_i = 1; host_we_i = 0; host_addr_i = 12'h020; host_wdata_i = '0;
        gnt_q.push_back(g_ent(c + 1, 1'b1, 1'b0, 12'h020, '0));
        rd_q.push_back(r_ent(c + 3, 1'b1, 32'h0000_0007));
        tick();
        host_req_i = 0;
        tick();
        sample(); check("rd_busy_read", busy_o, 1);
        tick();
        sample(); check("rd_busy_c3", busy_o, 0);
        check("rd_cpu_rdata_untouched", cpu_rdata_o, 32'h0);
        tick();
        sample(); check("rd_host_rdata_hold", host_rdata_o, 32'h0000_0007);

        // fresh reset so arbitration history starts clean
        tick();
        nrst = 0;
        tick();
        check("rst2_host_rdata", host_rdata_o, 32'h0);
        nrst = 1;
        tick();

        // contention, both held for 4 write accesses
        c = cyc;
        cpu_req_i = 1; cpu_we_i = 1; cpu_addr_i = 12'h100; cpu_wdata_i = 32'hC0C0_C0C0;
        host_req_i = 1; host_we_i = 1; host_addr_i = 12'h200; host_wdata_i = 32'h4848_4848;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_PORT_ARB_RR_EN
            if (i % 2 == 0) gnt_q.push_back(g_ent(c + 1 + 2 * i, 1'b1, 1'b1, 12'h200, 32'h4848_4848));
            else            gnt_q.push_back(g_ent(c + 1 + 2 * i, 1'b0, 1'b1, 12'h100, 32'hC0C0_C0C0));
`else
            gnt_q.push_back(g_ent(c + 1 + 2 * i, 1'b1, 1'b1, 12'h200, 32'h4848_4848));
`endif
        end
        for (int i = 0; i < 8; i++) begin
            sample();
`ifndef MEM_PORT_ARB_RR_EN
            check("contend_stall_held", cpu_stall_o, 1);
`endif
            tick();
        end
        clear_inputs();
        tick();

        // host lock holds the CPU off
        host_lock_i = 1;
        cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 12'h001; cpu_wdata_i = '0;
        for (int i = 0; i < 10; i++) begin
            sample();
            check("lock_no_gnt", cpu_gnt_o, 0);
            check("lock_not_busy", busy_o, 0);
            tick();
        end
        host_lock_i = 0;
        c = cyc;
        gnt_q.push_back(g_ent(c + 1, 1'b0, 1'b0, 12'h001, '0));
        rd_q.push_back(r_ent(c + 3, 1'b0, 32'h1111_1111));
        found = 0;
        for (int i = 0; i < 2 && !found; i++) begin
            sample();
            if (cpu_gnt_o) found = 1;
        end
        check("lock_release_gnt", found, 1);
        tick();
        cpu_req_i = 0;
        tick(); tick();

        // back-to-back CPU reads
        rv_cyc_q.delete();
        c = cyc;
        cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 12'h001;
        gnt_q.push_back(g_ent(c + 1, 1'b0, 1'b0, 12'h001, '0));
        rd_q.push_back(r_ent(c + 3, 1'b0, 32'h1111_1111));
        gnt_q.push_back(g_ent(c + 4, 1'b0, 1'b0, 12'h002, '0));
        rd_q.push_back(r_ent(c + 6, 1'b0, 32'h2222_2222));
        tick(); tick(); tick();
        cpu_addr_i = 12'h002;
        tick(); tick();
        cpu_req_i = 0;
        tick(); tick();
        sample();
        check("b2b_rvalid_count", rv_cyc_q.size(), 2);
        check("b2b_rvalid_spacing", (rv_cyc_q.size() == 2) ? rv_cyc_q[1] - rv_cyc_q[0] : -1, 3);
        check("b2b_rdata_hold", cpu_rdata_o, 32'h2222_2222);

        // reset during READ aborts the access
        tick();
        c = cyc;
        host_req_i = 1; host_we_i = 0; host_addr_i = 12'h020;
        gnt_q.push_back(g_ent(c + 1, 1'b1, 1'b0, 12'h020, '0));
        tick();
        host_req_i = 0;
        tick();
        #2;
        check("midrd_busy_before", busy_o, 1);
        nrst = 0;
        #1;
        check("midrd_busy_async", busy_o, 0);
        check("midrd_strobes_async", {ram_we_o, ram_re_o}, 0);
        tick();
        nrst = 1;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("midrd_no_rvalid", host_rvalid_o, 0);
            check("midrd_rdata_cleared", host_rdata_o, 32'h0);
            tick();
        end

        check("gnt_queue_drained", gnt_q.size(), 0);
        check("rd_queue_drained", rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter for the single data port of the shared instruction/data RAM. Two requesters compete for this port: the CPU datapath (load/store) and the FPGA host/calculator front-end (program load, result readback). The block replaces the static enable-driven muxes in front of the RAM data port. It serialises accesses through a small FSM, returns read data with a fixed latency, and can lock the CPU out while the host performs a bulk load. The instruction fetch port is not touched.

## Interface
- AW, default 12: RAM word-address width.
- DW, default 32: data width.
- clk  in  1  system clock.
- nrst  in  1  reset; asynchronous, active-low.
- cpu_req_i  in  1  CPU access request; sampled only in IDLE.
- cpu_we_i  in  1  1 = write, 0 = read.
- cpu_addr_i  in  AW  CPU address.
- cpu_wdata_i  in  DW  CPU write data.
- cpu_gnt_o  out  1  one-cycle pulse when the CPU access is issued to RAM.
- cpu_rvalid_o  out  1  one-cycle pulse; cpu_rdata_o is valid.
- cpu_rdata_o  out  DW  CPU read data; holds its value until the next CPU read.
- host_req_i, host_we_i, host_addr_i, host_wdata_i, host_gnt_o, host_rvalid_o, host_rdata_o: same as the cpu_* ports, for the host.
- host_lock_i  in  1  while high, CPU requests are never granted.
- ram_we_o  out  1  RAM write strobe.
- ram_re_o  out  1  RAM read strobe.
- ram_addr_o  out  AW  RAM address.
- ram_wdata_o  out  DW  RAM write data.
- ram_rdata_i  in  DW  RAM read data; valid in the cycle after ram_re_o.
- cpu_stall_o  out  1  combinational: cpu_req_i & ~cpu_gnt_o; cpu_req_i & ~cpu_gnt_o & ~cpu_rvalid_o is NOT used.
- busy_o  out  1  high whenever state is not IDLE.

## Operation
- FSM states:
  - IDLE: no access in progress.
  - ACCESS: RAM strobes driven.
  - READ: RAM returns data.
- IDLE, no eligible request: stay in IDLE.
  - A request is eligible if req is high; for the CPU, additionally host_lock_i must be low.
- IDLE with an eligible request:
  - Latch owner, we, addr and wdata into registers.
  - Go to ACCESS.
- ACCESS:
  - Outputs:
    - ram_we_o = latched we.
    - ram_re_o = ~latched we.
    - ram_addr_o = latched addr.
    - ram_wdata_o = latched wdata.
    - Owner's gnt_o = 1.
  - Next state: IDLE if write, READ if read.
- READ:
  - Register ram_rdata_i into the owner's rdata register.
  - Go to IDLE.
  - The owner's rvalid_o is asserted in the following cycle.
- Arbitration when both requests are eligible in IDLE:
  - Macro absent: host wins.
  - Macro present: round-robin, see Configuration.
- Requesters are not required to drop req after gnt. A request still high when the FSM next reaches IDLE is a new transaction.
- RAM outputs are 0 in IDLE and READ. ram_we_o and ram_re_o are never high together.
- host_lock_i rising while a CPU access is in ACCESS or READ does not abort that access.

## Timing
- Reset values:
  - All outputs are 0, except cpu_stall_o, which follows cpu_req_i.
  - State = IDLE; latched registers = 0; last_owner = CPU.
- Asserting nrst mid-access aborts it immediately: no gnt, no rvalid, RAM strobes drop asynchronously.
- Request high in cycle 0 (IDLE):
  - Cycle 1: ACCESS, gnt high.
  - Write: cycle 2 is IDLE.
  - Read: cycle 2 is READ; cycle 3 has rvalid high with data, state IDLE.
- Throughput:
  - Writes: one per 2 cycles.
  - Reads: one per 3 cycles. The rvalid cycle overlaps the next request's sampling cycle.
- Address and data are used at full width, with no truncation inside the block. The top level connects ram_addr_o to the RAM's 12-bit address.

## Configuration
- MEM_PORT_ARB_RR_EN, defined:
  - Round-robin. With both eligible, the requester that is not last_owner wins.
  - last_owner updates on every IDLE→ACCESS transition.
  - First contention after reset goes to the host.
- Undefined: fixed priority, host over CPU. last_owner is not implemented.
- host_lock_i behaviour is identical in both builds.

## Structure
- Package mem_port_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCESS, READ} arb_state_t.
  - typedef enum logic {OWN_CPU, OWN_HOST} arb_owner_t.
- Sub-module mem_port_arb_pick: combinational winner selection.
  - Inputs: both eligibility signals and last_owner.
  - Output: winner.
  - The `ifdef` for MEM_PORT_ARB_RR_EN lives inside it.
- Top module: FSM, latch registers, rdata registers, output decode.

## Test plan
- CPU write only:
  - Stimulus: cpu_req_i=1, we=1, addr=0x010, wdata=0xDEADBEEF in cycle 0.
  - Response: cycle 1 has ram_we_o=1, ram_addr_o=0x010, ram_wdata_o=0xDEADBEEF, cpu_gnt_o=1. Cycle 2 busy_o=0.
- Host read:
  - Stimulus: host addr=0x020, RAM returns 0x00000007.
  - Response: cycle 1 ram_re_o=1. Cycle 3 host_rvalid_o=1, host_rdata_o=0x7. cpu_rvalid_o stays 0.
- Simultaneous requests, held for 4 accesses:
  - Without the macro: grant order H,H,H,H; cpu_stall_o stays 1.
  - With MEM_PORT_ARB_RR_EN: grant order H,C,H,C.
- host_lock_i=1 with cpu_req_i held for 10 cycles:
  - Response: no cpu_gnt_o.
  - Dropping lock gives cpu_gnt_o within 2 cycles when the host is idle.
- Reset mid-read:
  - Stimulus: nrst=0 during READ.
  - Response: state IDLE and all RAM strobes 0 immediately; no rvalid after release.
- Back-to-back CPU reads, addr 0x001 then 0x002:
  - Response: rvalid pulses 3 cycles apart, carrying the correct data in order.
